spi_seq: RTL and testbench
==========================

# spi_seq

Transaction sequencer for the SPI byte engine (`spi`). Accepts a multi-byte command (length plus a byte stream), issues bytes to the engine one at a time, and returns every received byte to the host. It owns the engine's chip-select, applying programmable setup, hold and inter-transaction gap timing. It sits between a host-side controller (register file or DMA) and the `spi` instance, so the engine never needs host-level byte sequencing.

## Interface
Parameters:
- `CS_SETUP`, 2: clk cycles from CS low to first byte issue (≥1).
- `CS_HOLD`, 2: clk cycles from last byte complete to CS high (≥1).
- `CS_GAP`, 4: minimum clk cycles CS stays high before next transaction (≥1).
- `TIMEOUT`, 1024: max clk cycles allowed per engine byte before abort.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  transaction request.
- `cmd_len`  in  8  byte count minus 1 (0 → 1 byte, 255 → 256 bytes).
- `cmd_ready`  out  1  high only in IDLE.
- `tx_valid`  in  1  host TX byte available.
- `tx_data`  in  8  TX byte.
- `tx_ready`  out  1  TX byte consumed this cycle.
- `rx_valid`  out  1  one-cycle pulse, RX byte valid; no backpressure.
- `rx_data`  out  8  received byte.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at end of transaction (after GAP).
- `err`  out  1  one-cycle pulse coincident with `done` when aborted by timeout.
- `eng_cs`  out  1  to engine `CS_input`; low = selected.
- `eng_valid`  out  1  one-cycle byte start to engine `valid`.
- `eng_data`  out  8  to engine `data_send`.
- `eng_ready`  in  1  from engine `ready`; high = idle/complete.
- `eng_rx`  in  8  from engine `data_receive`.

## Operation
- States: IDLE, SETUP, FETCH, ISSUE, WAIT_ACC, WAIT_DONE, HOLD, GAP.
- IDLE: `cmd_ready`=1. When `cmd_valid`=1: latch `cmd_len` into a remaining-byte counter, drive `eng_cs`=0, load the timing counter with `CS_SETUP`, go to SETUP.
- SETUP: count down; at zero go to FETCH.
- FETCH: wait for `tx_valid`. While waiting, CS stays low indefinitely and the timeout does not run. When `tx_valid` is high: `tx_ready`=1 for that cycle, register `tx_data` into `eng_data`, go to ISSUE.
- ISSUE: `eng_valid`=1 for exactly one cycle. Clear the timeout counter and go to WAIT_ACC.
- WAIT_ACC: wait for `eng_ready`=0 (byte accepted), then go to WAIT_DONE.
- WAIT_DONE: wait for `eng_ready`=1. On that cycle register `eng_rx` into `rx_data` and pulse `rx_valid` on the next cycle. If the remaining count is 0, load `CS_HOLD` and go to HOLD; otherwise decrement the count and go to FETCH.
- Timeout: a counter runs in WAIT_ACC and WAIT_DONE. On reaching `TIMEOUT`, set the abort flag, produce no `rx_valid`, and go to HOLD.
- HOLD: count down `CS_HOLD`; at zero drive `eng_cs`=1, load `CS_GAP`, go to GAP.
- GAP: count down; at zero pulse `done` (and `err` if the abort flag is set), clear the flag, go to IDLE.
- `cmd_valid` is ignored outside IDLE. `cmd_len` is sampled only on acceptance.
- `eng_data` holds its value until the next FETCH.

## Timing
- Reset values (`rst`=0 at a clk edge): state IDLE, `eng_cs`=1, `eng_valid`=0, `eng_data`=0, `tx_ready`=0, `rx_valid`=0, `rx_data`=0, `busy`=0, `done`=0, `err`=0, `cmd_ready`=1 after release.
- Reset mid-transaction takes effect on the same edge: CS goes high immediately, with no hold or gap applied and no `done`.
- Accept cycle T: `eng_cs` falls at T+1. The first `eng_valid` occurs no earlier than T+1+`CS_SETUP`+1, given `tx_valid` already high.
- Minimum per-byte overhead beyond engine time: 3 clk (FETCH, ISSUE, capture).
- `rx_valid` for byte k precedes `tx_ready` for byte k+1.
- Last `eng_ready` rise to `eng_cs` rise: `CS_HOLD`+1 clk.
- `eng_cs` rise to `done`: `CS_GAP` clk. `cmd_ready` is high the cycle after `done`.
- Back-to-back commands: CS high time is always ≥ `CS_GAP`.
- Counts: a 256-byte transaction produces exactly 256 `tx_ready` and 256 `rx_valid` pulses, with no wrap.

## Test plan
- Single byte, `cmd_len`=0, `tx_data`=8'hAF, engine MISO looped to MOSI → one `eng_valid`, `rx_data`=8'hAF, one `done`, `err`=0, CS low for exactly one byte frame plus setup/hold.
- Three bytes 8'h55, 8'h0F, 8'hF0 with `tx_valid` deasserted for 50 clk before byte 2 → CS stays low throughout; `rx_valid` ×3 with matching data, in order.
- Timing check with defaults: CS fall to first `eng_valid` = 3 clk; last `eng_ready` rise to CS rise = 3 clk; CS rise to `done` = 4 clk.
- Two commands issued back-to-back, `cmd_valid` held high → second accepted only after `done`; CS high ≥ 4 clk between them.
- Engine `ready` held low after `valid`, with `TIMEOUT`=64 → abort after 64 clk; no `rx_valid`; `done` and `err` pulse together; CS returns high.
- `rst`=0 asserted mid byte 2 of 4 → next edge: `eng_cs`=1, `busy`=0, no `done`; a new command then completes normally.

Source files
------------

// File: rtl/spi_seq.sv
// Transaction sequencer for the SPI byte engine: streams host TX bytes to the
// engine one at a time, returns RX bytes, and owns chip-select setup/hold/gap timing.
module spi_seq #(
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_GAP   = 4,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_len,
    output logic       cmd_ready,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       eng_cs,
    output logic       eng_valid,
    output logic [7:0] eng_data,
    input  logic       eng_ready,
    input  logic [7:0] eng_rx
);

    localparam int unsigned CW = 16;
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        IDLE, SETUP, FETCH, ISSUE, WAIT_ACC, WAIT_DONE, HOLD, GAP
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [7:0]      rem;
    logic [TW-1:0]   tout;
    logic            abort;
    logic            cnt_zero;
    logic            tout_hit;

    assign cnt_zero  = (cnt == '0);
    assign tout_hit  = (tout == TW'(TIMEOUT - 1));
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        tx_ready   = 1'b0;
        eng_valid  = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE:      if (cmd_valid) state_next = SETUP;
            SETUP:     if (cnt_zero) state_next = FETCH;
            FETCH: begin
                if (tx_valid) begin
                    tx_ready   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                eng_valid  = 1'b1;
                state_next = WAIT_ACC;
            end
            WAIT_ACC: begin
                if (tout_hit)        state_next = HOLD;
                else if (!eng_ready) state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (eng_ready)     state_next = (rem == '0) ? HOLD : FETCH;
                else if (tout_hit) state_next = HOLD;
            end
            HOLD:      if (cnt_zero) state_next = GAP;
            GAP: begin
                if (cnt_zero) begin
                    done       = 1'b1;
                    err        = abort;
                    state_next = IDLE;
                end
            end
            default:   state_next = IDLE;
        endcase
    end

    // SETUP/HOLD count to zero inclusive from N-1 (N cycles); GAP counts from
    // N so done lands CS_GAP cycles after CS rises, with IDLE on the cycle after.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            tout     <= '0;
            abort    <= 1'b0;
            eng_cs   <= 1'b1;
            eng_data <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            state    <= state_next;
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        rem    <= cmd_len;
                        cnt    <= CW'(CS_SETUP - 1);
                        eng_cs <= 1'b0;
                    end
                end
                SETUP:     if (!cnt_zero) cnt <= cnt - 1'b1;
                FETCH:     if (tx_valid) eng_data <= tx_data;
                ISSUE:     tout <= '0;
                WAIT_ACC: begin
                    tout <= tout + 1'b1;
                    if (tout_hit) begin
                        abort <= 1'b1;
                        cnt   <= CW'(CS_HOLD - 1);
                    end
                end
                WAIT_DONE: begin
                    tout <= tout + 1'b1;
                    if (eng_ready) begin
                        rx_data  <= eng_rx;
                        rx_valid <= 1'b1;
                        if (rem == '0) cnt <= CW'(CS_HOLD - 1);
                        else           rem <= rem - 1'b1;
                    end else if (tout_hit) begin
                        abort <= 1'b1;
                        cnt   <= CW'(CS_HOLD - 1);
                    end
                end
                HOLD: begin
                    if (cnt_zero) begin
                        eng_cs <= 1'b1;
                        cnt    <= CW'(CS_GAP);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_zero) abort <= 1'b0;
                    else          cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_seq.sv
// Directed bench for spi_seq with a loopback engine model (MISO = MOSI byte).
module tb_spi_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_len = '0;
    logic       cmd_ready;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy, done, err;
    logic       eng_cs, eng_valid;
    logic [7:0] eng_data;
    logic       eng_ready = 1'b1;
    logic [7:0] eng_rx = '0;

    spi_seq #(.CS_SETUP(2), .CS_HOLD(2), .CS_GAP(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .busy(busy), .done(done), .err(err),
        .eng_cs(eng_cs), .eng_valid(eng_valid), .eng_data(eng_data),
        .eng_ready(eng_ready), .eng_rx(eng_rx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor state (sampled on the falling edge)
    int   cyc = 0;
    int   t_acc, t_cs_fall, t_cs_rise, t_first, t_rdy_rise, t_done;
    int   lo_w, hi_w;
    int   n_acc, n_valid, n_txr, n_rx, n_done, n_err, n_stray, n_order, n_cs_fall, n_cs_rise;
    bit   first_pend, rx_owed, prev_done, rdy_after_done, rdy_at_done;
    bit   prev_cs = 1'b1, prev_rdy = 1'b1;
    bit   valid_seen, rst_seen;
    logic [7:0] data_seen;
    logic [7:0] rx_log [1024];
    logic [7:0] tx_bytes [256];

    always @(negedge clk) begin
        cyc++;
        rst_seen   = rst;
        valid_seen = eng_valid;
        data_seen  = eng_data;
        if (prev_done) rdy_after_done = cmd_ready;
        prev_done = done;
        if (cmd_valid && cmd_ready) begin
            n_acc++; t_acc = cyc; first_pend = 1'b1; rx_owed = 1'b0;
        end
        if (eng_valid) begin
            n_valid++;
            if (first_pend) begin t_first = cyc; first_pend = 1'b0; end
        end
        if (prev_cs && !eng_cs) begin n_cs_fall++; t_cs_fall = cyc; hi_w = cyc - t_cs_rise; end
        if (!prev_cs && eng_cs) begin n_cs_rise++; t_cs_rise = cyc; lo_w = cyc - t_cs_fall; end
        prev_cs = eng_cs;
        if (!prev_rdy && eng_ready) t_rdy_rise = cyc;
        prev_rdy = eng_ready;
        if (rx_valid) begin rx_log[n_rx] = rx_data; n_rx++; rx_owed = 1'b0; end
        if (tx_ready) begin
            if (rx_owed) n_order++;
            rx_owed = 1'b1;
            n_txr++;
        end
        if (done) begin
            n_done++; t_done = cyc; rdy_at_done = cmd_ready;
            if (err) n_err++;
        end
        if (err && !done) n_stray++;
    end

    // Engine model: ready drops the cycle after valid, rises ENG_LEN cycles later
    localparam int ENG_LEN = 4;
    bit         stuck = 1'b0;
    bit         e_busy = 1'b0;
    int         e_frame;
    logic [7:0] e_shift;

    always @(posedge clk) begin
        #1;
        if (!rst_seen) begin
            eng_ready = 1'b1; e_busy = 1'b0;
        end else if (valid_seen) begin
            eng_ready = 1'b0; e_busy = 1'b1; e_frame = ENG_LEN; e_shift = data_seen;
        end else if (e_busy && !stuck) begin
            if (e_frame <= 1) begin
                eng_ready = 1'b1; eng_rx = e_shift; e_busy = 1'b0;
            end else begin
                e_frame--;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input int n, input bit gap2, input bit hold_valid);
        int k;
        cmd_valid = 1'b1;
        cmd_len   = 8'(n - 1);
        k = 0;
        do begin @(negedge clk); k++; end while (!cmd_ready && k < 500);
        check("accept", cmd_ready, 1);
        step();
        if (!hold_valid) cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gap2 && i == 1) begin
                tx_valid = 1'b0;
                repeat (50) step();
            end
            tx_valid = 1'b1;
            tx_data  = tx_bytes[i];
            k = 0;
            do begin @(negedge clk); k++; end while (!tx_ready && k < 200);
            if (!tx_ready) begin
                check("tx_ready wait", 0, 1);
                break;
            end
            step();
        end
        tx_valid = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!done && k < 5000);
        if (!done) check("done wait", 0, 1);
        step();
    endtask

    int b_valid, b_rx, b_done, b_err, b_acc, b_txr, b_order, b_fall, b_rise, b_stray;
    int d1, mism, k;

    task automatic snap();
        b_valid = n_valid; b_rx = n_rx; b_done = n_done; b_err = n_err; b_acc = n_acc;
        b_txr = n_txr; b_order = n_order; b_fall = n_cs_fall; b_rise = n_cs_rise; b_stray = n_stray;
    endtask

    initial begin
        // Reset state (tx_valid high to show tx_ready is gated by state)
        rst = 1'b0;
        tx_valid = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("rst eng_cs", eng_cs, 1);
        check("rst eng_valid", eng_valid, 0);
        check("rst eng_data", eng_data, 0);
        check("rst tx_ready", tx_ready, 0);
        check("rst rx_valid", rx_valid, 0);
        check("rst rx_data", rx_data, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst err", err, 0);
        check("rst cmd_ready", cmd_ready, 1);
        step();
        rst = 1'b1;
        tx_valid = 1'b0;
        step();

        // Single byte AF
        tx_bytes[0] = 8'hAF;
        snap();
        run_cmd(1, 1'b0, 1'b0);
        check("t1 eng_valid count", n_valid - b_valid, 1);
        check("t1 rx count", n_rx - b_rx, 1);
        check("t1 rx byte", rx_log[b_rx], 8'hAF);
        check("t1 rx_data", rx_data, 8'hAF);
        check("t1 done count", n_done - b_done, 1);
        check("t1 err count", n_err - b_err, 0);
        check("t1 accept->cs fall", t_cs_fall - t_acc, 1);
        check("t1 cs fall->valid", t_first - t_cs_fall, 3);
        check("t1 ready rise->cs rise", t_cs_rise - t_rdy_rise, 3);
        check("t1 cs rise->done", t_done - t_cs_rise, 4);
        check("t1 cs low width", lo_w, 11);
        step();
        check("t1 cmd_ready at done", rdy_at_done, 0);
        check("t1 cmd_ready after done", rdy_after_done, 1);

        // Three bytes with a 50-cycle host stall before byte 2
        tx_bytes[0] = 8'h55; tx_bytes[1] = 8'h0F; tx_bytes[2] = 8'hF0;
        snap();
        run_cmd(3, 1'b1, 1'b0);
        check("t2 rx count", n_rx - b_rx, 3);
        check("t2 rx0", rx_log[b_rx], 8'h55);
        check("t2 rx1", rx_log[b_rx + 1], 8'h0F);
        check("t2 rx2", rx_log[b_rx + 2], 8'hF0);
        check("t2 cs falls", n_cs_fall - b_fall, 1);
        check("t2 cs rises", n_cs_rise - b_rise, 1);
        check("t2 rx before next tx", n_order - b_order, 0);
        check("t2 eng_valid count", n_valid - b_valid, 3);
        check("t2 done count", n_done - b_done, 1);

        // Back-to-back commands with cmd_valid held high
        tx_bytes[0] = 8'h3C;
        snap();
        run_cmd(1, 1'b0, 1'b1);
        d1 = t_done;
        check("t3 accepts during first", n_acc - b_acc, 1);
        tx_bytes[0] = 8'hC3;
        run_cmd(1, 1'b0, 1'b0);
        check("t3 second accept after done", t_acc - d1, 1);
        check("t3 cs high width", hi_w, 6);
        check("t3 cs high >= gap", hi_w >= 4, 1);
        check("t3 accepts total", n_acc - b_acc, 2);
        check("t3 second rx", rx_log[n_rx - 1], 8'hC3);

        // 256-byte transaction
        for (int i = 0; i < 256; i++) tx_bytes[i] = 8'(i) ^ 8'h5A;
        snap();
        run_cmd(256, 1'b0, 1'b0);
        check("t4 tx_ready count", n_txr - b_txr, 256);
        check("t4 rx count", n_rx - b_rx, 256);
        check("t4 eng_valid count", n_valid - b_valid, 256);
        mism = 0;
        for (int i = 0; i < 256; i++) if (rx_log[b_rx + i] !== tx_bytes[i]) mism++;
        check("t4 rx data mismatches", mism, 0);
        check("t4 order", n_order - b_order, 0);
        check("t4 err count", n_err - b_err, 0);
        check("t4 done count", n_done - b_done, 1);

        // Engine stalls: timeout abort
        stuck = 1'b1;
        tx_bytes[0] = 8'h99;
        snap();
        run_cmd(1, 1'b0, 1'b0);
        check("t5 rx count", n_rx - b_rx, 0);
        check("t5 done count", n_done - b_done, 1);
        check("t5 err with done", n_err - b_err, 1);
        check("t5 stray err", n_stray - b_stray, 0);
        check("t5 valid->cs rise", t_cs_rise - t_first, 67);
        check("t5 cs rise->done", t_done - t_cs_rise, 4);
        check("t5 eng_cs", eng_cs, 1);
        stuck = 1'b0;
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();

        // Reset during byte 2 of 4
        snap();
        cmd_valid = 1'b1;
        cmd_len   = 8'd3;
        tx_valid  = 1'b1;
        tx_data   = 8'h11;
        k = 0;
        while (n_valid < b_valid + 2 && k < 500) begin step(); k++; end
        check("t6 reached byte 2", n_valid - b_valid, 2);
        step();
        check("t6 busy before reset", busy, 1);
        check("t6 cs low before reset", eng_cs, 0);
        rst = 1'b0;
        cmd_valid = 1'b0;
        tx_valid = 1'b0;
        step();
        check("t6 eng_cs after reset", eng_cs, 1);
        check("t6 busy after reset", busy, 0);
        check("t6 done after reset", done, 0);
        repeat (2) step();
        rst = 1'b1;
        repeat (10) step();
        check("t6 no done", n_done - b_done, 0);
        tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h3C;
        snap();
        run_cmd(2, 1'b0, 1'b0);
        check("t6 rx count", n_rx - b_rx, 2);
        check("t6 rx0", rx_log[b_rx], 8'hA5);
        check("t6 rx1", rx_log[b_rx + 1], 8'h3C);
        check("t6 done count", n_done - b_done, 1);
        check("t6 err count", n_err - b_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time %0t reached, expected finish before 1000000", $time);
        $fatal(1, "watchdog");
    end

endmodule
